// File: rtl/serial_rx_ctrl_32_w_pkg.sv
// Shared widths and small helpers for the serial frame receiver.
// Latency: n/a (compile-time definitions only).
// Backpressure: n/a.
package serial_rx_ctrl_32_w_pkg;

    localparam int BYTE_W  = 8;
    localparam int WORD_W  = 16;
    localparam int GAP_W   = 16;
    localparam int STATE_W = 3;

    // Data words and CRC values travel high byte first on the wire.
    function automatic logic [WORD_W-1:0] join_bytes(input logic [BYTE_W-1:0] hi,
                                                     input logic [BYTE_W-1:0] lo);
        return {hi, lo};
    endfunction

    // A byte is announced by the rising edge of the UART done flag.
    function automatic logic is_rise(input logic now_lvl, input logic prev_lvl);
        return now_lvl & ~prev_lvl;
    endfunction

endpackage

// File: rtl/serial_rx_ctrl_32_w.sv
// Serial frame receiver: assembles n_word 16-bit words from UART bytes, feeds an external CRC, checks the trailing CRC.
// Latency: every output is registered; strobes appear one cycle after the rx_done rising edge, the verdict one cycle after CHECK.
// Backpressure: none; the UART cannot be stalled, so an inter-byte gap beyond timeout aborts the frame and returns to idle.
module serial_rx_ctrl_32_w
    import serial_rx_ctrl_32_w_pkg::*;
#(
    parameter logic [7:0]  n_word  = 8'h01,
    parameter logic [15:0] timeout = 16'd5000
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [BYTE_W-1:0]   byte_in,
    input  logic                rx_done,
    input  logic [WORD_W-1:0]   crc_16,
    output logic [WORD_W-1:0]   data_out,
    output logic [7:0]          data_select,
    output logic                data_wr,
    output logic [BYTE_W-1:0]   crc_byte,
    output logic                crc_en,
    output logic                reset_crc,
    output logic                ready,
    output logic                frame_ok,
    output logic                crc_err,
    output logic                timeout_err
);

    localparam logic [STATE_W-1:0] S_IDLE      = 3'd0;
    localparam logic [STATE_W-1:0] S_RX_HI     = 3'd1;
    localparam logic [STATE_W-1:0] S_RX_LO     = 3'd2;
    localparam logic [STATE_W-1:0] S_RX_CRC_HI = 3'd3;
    localparam logic [STATE_W-1:0] S_RX_CRC_LO = 3'd4;
    localparam logic [STATE_W-1:0] S_CHECK     = 3'd5;

    localparam logic [7:0] LAST_SEL = 8'(n_word - 8'd1);

    logic [STATE_W-1:0] state_q,       state_d;
    logic               rx_done_q,     rx_done_d;
    logic [GAP_W-1:0]   gap_q,         gap_d;
    logic [BYTE_W-1:0]  hi_q,          hi_d;
    logic [BYTE_W-1:0]  crc_hi_q,      crc_hi_d;
    logic [BYTE_W-1:0]  crc_lo_q,      crc_lo_d;
    logic [WORD_W-1:0]  data_out_q,    data_out_d;
    logic [7:0]         data_select_q, data_select_d;
    logic               data_wr_q,     data_wr_d;
    logic [BYTE_W-1:0]  crc_byte_q,    crc_byte_d;
    logic               crc_en_q,      crc_en_d;
    logic               reset_crc_q,   reset_crc_d;
    logic               ready_q,       ready_d;
    logic               frame_ok_q,    frame_ok_d;
    logic               crc_err_q,     crc_err_d;
    logic               timeout_err_q, timeout_err_d;

    logic byte_ev;
    logic gap_active;
    logic gap_hit;

    // Byte event detection and gap-counter qualification.
    always_comb begin
        rx_done_d  = rx_done;
        byte_ev    = is_rise(rx_done, rx_done_q);
        gap_active = (state_q != S_IDLE) && (state_q != S_CHECK);
        gap_hit    = gap_active && (gap_q >= timeout);
    end

    // Next-state and next-output computation for the frame FSM.
    always_comb begin
        state_d       = state_q;
        hi_d          = hi_q;
        crc_hi_d      = crc_hi_q;
        crc_lo_d      = crc_lo_q;
        data_out_d    = data_out_q;
        data_select_d = data_select_q;
        crc_byte_d    = crc_byte_q;
        data_wr_d     = 1'b0;
        crc_en_d      = 1'b0;
        frame_ok_d    = 1'b0;
        crc_err_d     = 1'b0;
        timeout_err_d = 1'b0;

        if (!gap_active || byte_ev) begin
            gap_d = '0;
        end else begin
            gap_d = GAP_W'(gap_q + 16'd1);
        end

        // Advance the word index once the write strobe has been seen,
        // unless that write was the last word of the frame.
        if (data_wr_q && (data_select_q != LAST_SEL)) begin
            data_select_d = 8'(data_select_q + 8'd1);
        end

        if (gap_hit) begin
            // Abort wins over any byte arriving in the same cycle.
            timeout_err_d = 1'b1;
            data_select_d = '0;
            gap_d         = '0;
            state_d       = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    data_select_d = '0;
                    if (byte_ev) begin
                        hi_d       = byte_in;
                        crc_byte_d = byte_in;
                        crc_en_d   = 1'b1;
                        state_d    = S_RX_LO;
                    end
                end
                S_RX_HI: begin
                    if (byte_ev) begin
                        hi_d       = byte_in;
                        crc_byte_d = byte_in;
                        crc_en_d   = 1'b1;
                        state_d    = S_RX_LO;
                    end
                end
                S_RX_LO: begin
                    if (byte_ev) begin
                        data_out_d = join_bytes(hi_q, byte_in);
                        data_wr_d  = 1'b1;
                        crc_byte_d = byte_in;
                        crc_en_d   = 1'b1;
                        state_d    = (data_select_q == LAST_SEL) ? S_RX_CRC_HI : S_RX_HI;
                    end
                end
                S_RX_CRC_HI: begin
                    if (byte_ev) begin
                        crc_hi_d = byte_in;
                        state_d  = S_RX_CRC_LO;
                    end
                end
                S_RX_CRC_LO: begin
                    if (byte_ev) begin
                        crc_lo_d = byte_in;
                        state_d  = S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (join_bytes(crc_hi_q, crc_lo_q) == crc_16) begin
                        frame_ok_d = 1'b1;
                    end else begin
                        crc_err_d = 1'b1;
                    end
                    data_select_d = '0;
                    state_d       = S_IDLE;
                end
                default: begin
                    data_select_d = '0;
                    state_d       = S_IDLE;
                end
            endcase
        end

        // Idle both advertises readiness and holds the CRC calculator clear.
        ready_d     = (state_d == S_IDLE);
        reset_crc_d = (state_d == S_IDLE);
    end

    // Edge-detect history follows rx_done even during reset so a level held
    // across reset release does not fake a byte.
    always_ff @(posedge clk) begin
        rx_done_q <= rx_done_d;
    end

    // State, stored bytes and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_IDLE;
            gap_q         <= '0;
            hi_q          <= '0;
            crc_hi_q      <= '0;
            crc_lo_q      <= '0;
            data_out_q    <= '0;
            data_select_q <= '0;
            data_wr_q     <= 1'b0;
            crc_byte_q    <= '0;
            crc_en_q      <= 1'b0;
            reset_crc_q   <= 1'b1;
            ready_q       <= 1'b0;
            frame_ok_q    <= 1'b0;
            crc_err_q     <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            gap_q         <= gap_d;
            hi_q          <= hi_d;
            crc_hi_q      <= crc_hi_d;
            crc_lo_q      <= crc_lo_d;
            data_out_q    <= data_out_d;
            data_select_q <= data_select_d;
            data_wr_q     <= data_wr_d;
            crc_byte_q    <= crc_byte_d;
            crc_en_q      <= crc_en_d;
            reset_crc_q   <= reset_crc_d;
            ready_q       <= ready_d;
            frame_ok_q    <= frame_ok_d;
            crc_err_q     <= crc_err_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign data_out    = data_out_q;
    assign data_select = data_select_q;
    assign data_wr     = data_wr_q;
    assign crc_byte    = crc_byte_q;
    assign crc_en      = crc_en_q;
    assign reset_crc   = reset_crc_q;
    assign ready       = ready_q;
    assign frame_ok    = frame_ok_q;
    assign crc_err     = crc_err_q;
    assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_serial_rx_ctrl_32_w.sv
// Bench for the serial frame receiver: random and directed frames against a queue-based reference.
// Latency: expectations are queued at stimulus time and consumed whenever the DUT strobes.
// Backpressure: none; the bench paces bytes like a UART would.
module tb_serial_rx_ctrl_32_w;

    localparam logic [7:0]  N_WORD  = 8'd3;
    localparam logic [15:0] TIMEOUT = 16'd100;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  byte_in;
    logic        rx_done;
    logic [15:0] crc_16;
    logic [15:0] data_out;
    logic [7:0]  data_select;
    logic        data_wr;
    logic [7:0]  crc_byte;
    logic        crc_en;
    logic        reset_crc;
    logic        ready;
    logic        frame_ok;
    logic        crc_err;
    logic        timeout_err;

    always #5 clk = ~clk;

    serial_rx_ctrl_32_w #(
        .n_word  (N_WORD),
        .timeout (TIMEOUT)
    ) u_dut (
        .clk         (clk),
        .reset       (reset),
        .byte_in     (byte_in),
        .rx_done     (rx_done),
        .crc_16      (crc_16),
        .data_out    (data_out),
        .data_select (data_select),
        .data_wr     (data_wr),
        .crc_byte    (crc_byte),
        .crc_en      (crc_en),
        .reset_crc   (reset_crc),
        .ready       (ready),
        .frame_ok    (frame_ok),
        .crc_err     (crc_err),
        .timeout_err (timeout_err)
    );

    // CRC-16/CCITT byte update, used both by the external calculator model
    // and by the stimulus to work out the CRC a sender would append.
    function automatic logic [15:0] crc_upd(input logic [15:0] c, input logic [7:0] b);
        logic [15:0] r;
        r = c ^ {b, 8'h00};
        for (int i = 0; i < 8; i++) begin
            r = r[15] ? ((r << 1) ^ 16'h1021) : (r << 1);
        end
        return r;
    endfunction

    // External CRC calculator driven by the DUT's CRC interface.
    logic [15:0] crc_reg;
    assign crc_16 = crc_reg;
    always @(posedge clk) begin
        if (reset_crc) crc_reg <= 16'hFFFF;
        else if (crc_en) crc_reg <= crc_upd(crc_reg, crc_byte);
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        logic [2:0] kind;   // {frame_ok, crc_err, timeout_err}
        int         at_cyc; // only meaningful for timeouts
    } res_t;

    logic [7:0]  exp_crc_q[$];
    logic [23:0] exp_wr_q[$];
    res_t        exp_res_q[$];

    int vectors     = 0;
    int miscompares = 0;
    int last_ev_cyc = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic monitor_step();
        res_t r;
        if (crc_en) begin
            if (exp_crc_q.size() == 0) chk("crc_en_unexpected", 32'(crc_en), 32'd0);
            else chk("crc_byte", 32'(crc_byte), 32'(exp_crc_q.pop_front()));
        end
        if (data_wr) begin
            if (exp_wr_q.size() == 0) chk("data_wr_unexpected", 32'(data_wr), 32'd0);
            else chk("data_wr_sel_word", 32'({data_select, data_out}), 32'(exp_wr_q.pop_front()));
        end
        if (frame_ok || crc_err || timeout_err) begin
            if (exp_res_q.size() == 0) begin
                chk("result_unexpected", 32'({frame_ok, crc_err, timeout_err}), 32'd0);
            end else begin
                r = exp_res_q.pop_front();
                chk("result_kind", 32'({frame_ok, crc_err, timeout_err}), 32'(r.kind));
                if (r.kind == 3'b001) chk("timeout_cycle", 32'(cyc), 32'(r.at_cyc));
            end
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input int hold, input int gap);
        byte_in     = b;
        rx_done     = 1'b1;
        last_ev_cyc = cyc + 1;
        repeat (hold) tick();
        rx_done = 1'b0;
        byte_in = 8'($urandom);
        repeat (gap) tick();
    endtask

    task automatic wait_results(input string name, input int limit);
        int n = 0;
        while (exp_res_q.size() != 0 && n < limit) begin
            tick();
            n++;
        end
        chk({name, "_pending"}, 32'(exp_res_q.size()), 32'd0);
        exp_res_q.delete();
    endtask

    task automatic send_frame(input logic [15:0] w [3], input logic [15:0] crc_xor, input int hold_first);
        logic [15:0] c;
        logic [15:0] tx;
        logic [7:0]  b;
        res_t        r;
        c = 16'hFFFF;
        for (int i = 0; i < 3; i++) begin
            for (int h = 0; h < 2; h++) begin
                b = (h == 0) ? w[i][15:8] : w[i][7:0];
                c = crc_upd(c, b);
                exp_crc_q.push_back(b);
                if (h == 1) exp_wr_q.push_back({8'(i), w[i]});
                send_byte(b, (i == 0 && h == 0) ? hold_first : int'($urandom_range(1, 3)),
                          int'($urandom_range(2, 8)));
            end
        end
        tx       = c ^ crc_xor;
        r.kind   = (crc_xor == 16'h0000) ? 3'b100 : 3'b010;
        r.at_cyc = 0;
        exp_res_q.push_back(r);
        send_byte(tx[15:8], int'($urandom_range(1, 3)), int'($urandom_range(2, 8)));
        send_byte(tx[7:0], 1, 1);
        wait_results("frame_result", 20);
        chk("ready_after_frame", 32'(ready), 32'd1);
        chk("reset_crc_after_frame", 32'(reset_crc), 32'd1);
        chk("data_out_held", 32'(data_out), 32'(w[2]));
        chk("data_select_cleared", 32'(data_select), 32'd0);
    endtask

    task automatic check_reset_vals(input string p);
        chk({p, "_data_out"},    32'(data_out),    32'd0);
        chk({p, "_data_select"}, 32'(data_select), 32'd0);
        chk({p, "_crc_byte"},    32'(crc_byte),    32'd0);
        chk({p, "_reset_crc"},   32'(reset_crc),   32'd1);
        chk({p, "_ready"},       32'(ready),       32'd0);
        chk({p, "_data_wr"},     32'(data_wr),     32'd0);
        chk({p, "_crc_en"},      32'(crc_en),      32'd0);
        chk({p, "_frame_ok"},    32'(frame_ok),    32'd0);
        chk({p, "_crc_err"},     32'(crc_err),     32'd0);
        chk({p, "_timeout_err"}, 32'(timeout_err), 32'd0);
    endtask

    task automatic drive_all();
        logic [15:0] w [3];
        res_t r;

        reset   = 1'b1;
        rx_done = 1'b0;
        byte_in = 8'h00;
        repeat (3) tick();
        check_reset_vals("por");
        reset = 1'b0;
        tick();
        chk("ready_after_reset", 32'(ready), 32'd1);

        // Directed good frame, then the same frame with a flipped CRC bit.
        w[0] = 16'h1234; w[1] = 16'h5678; w[2] = 16'h9ABC;
        send_frame(w, 16'h0000, 1);
        send_frame(w, 16'h0001, 1);

        // Two bytes then silence: abort after the configured gap.
        exp_crc_q.push_back(8'hA1);
        send_byte(8'hA1, 1, 3);
        exp_crc_q.push_back(8'hB2);
        exp_wr_q.push_back({8'd0, 16'hA1B2});
        send_byte(8'hB2, 1, 1);
        r.kind   = 3'b001;
        r.at_cyc = last_ev_cyc + 101;
        exp_res_q.push_back(r);
        wait_results("timeout_result", 130);
        chk("ready_after_timeout", 32'(ready), 32'd1);
        chk("reset_crc_after_timeout", 32'(reset_crc), 32'd1);
        chk("select_after_timeout", 32'(data_select), 32'd0);
        w[0] = 16'hBEEF; w[1] = 16'h0102; w[2] = 16'hFFFF;
        send_frame(w, 16'h0000, 1);

        // First byte held high for 20 cycles must count once.
        w[0] = 16'hCAFE; w[1] = 16'h0000; w[2] = 16'h7E81;
        send_frame(w, 16'h0000, 20);

        // Reset after the third byte of a frame.
        exp_crc_q.push_back(8'h11);
        send_byte(8'h11, 1, 2);
        exp_crc_q.push_back(8'h22);
        exp_wr_q.push_back({8'd0, 16'h1122});
        send_byte(8'h22, 1, 2);
        exp_crc_q.push_back(8'h33);
        send_byte(8'h33, 1, 2);
        reset = 1'b1;
        tick();
        check_reset_vals("midframe");
        reset = 1'b0;
        tick();
        chk("ready_after_midframe_reset", 32'(ready), 32'd1);
        w[0] = 16'h4455; w[1] = 16'h6677; w[2] = 16'h8899;
        send_frame(w, 16'h0000, 1);

        // Randomized frames, roughly one in three with a corrupted CRC.
        for (int k = 0; k < 20; k++) begin
            for (int i = 0; i < 3; i++) w[i] = 16'($urandom);
            send_frame(w, ($urandom_range(0, 2) == 0) ? 16'($urandom_range(1, 65535)) : 16'h0000,
                       int'($urandom_range(1, 4)));
        end

        repeat (4) tick();
        chk("crc_queue_drained", 32'(exp_crc_q.size()), 32'd0);
        chk("wr_queue_drained", 32'(exp_wr_q.size()), 32'd0);
    endtask

    initial begin
        fork
            begin
                forever begin
                    @(negedge clk);
                    monitor_step();
                end
            end
            begin
                drive_all();
            end
        join_any
        disable fork;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
